uc_seq: RTL and testbench
=========================

Name: uc_seq

Overview:
- Sequencing control unit that drives the single-cycle CPU datapath.
- Consumes the datapath's `opcode[5:0]` (instruction bits 15:10) and registered zero flag `z`.
- Produces every datapath select and write-enable, plus a PC-enable for multi-cycle stalls.
- Adds sequential behaviour on top of plain decode: WAIT stalls, HALT, call-stack depth tracking with overflow/underflow fault, illegal-opcode fault.

Parameters:
- `STACK_DEPTH`, 16: entries in the datapath return-address stack. Legal range 1..255.
- `WAIT_CYCLES`, 4: extra stall cycles inserted by WAIT. Must be ≥ 1.
- `DEPTH_W`, 8: width of the internal depth counter. Must satisfy 2^DEPTH_W > STACK_DEPTH.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `opcode`  in  6  current instruction opcode from the datapath.
- `z`  in  1  zero flag from the datapath flag flop.
- `s_inc`  out  1  1 = PC+1, 0 = jump target (instr[9:0]).
- `s_inm`  out  1  1 = register write data from the immediate/memory mux, 0 = from the ALU.
- `s_data`  out  1  1 = data memory, 0 = immediate instr[11:4].
- `s_pila`  out  1  1 = next PC comes from the stack (RET).
- `we3`  out  1  register file write enable.
- `wez`  out  1  zero-flag write enable.
- `we4`  out  1  data memory write enable.
- `push`  out  1  stack push; the stack stores the return address.
- `pop`  out  1  stack pop.
- `op_alu`  out  3  ALU operation.
- `pc_en`  out  1  PC load enable; 0 holds PC and the instruction.
- `halted`  out  1  core stopped by HALT.
- `fault`  out  1  core stopped by an error.
- `fault_code`  out  2  00 none, 01 illegal opcode, 10 stack overflow, 11 stack underflow.

Behaviour:
- Decided: one clock `clk`; `reset` is synchronous, active-low.
- While `reset` = 0:
  - All enables (`we3`, `wez`, `we4`, `push`, `pop`) are 0 and `pc_en` = 0.
  - All selects are 0, except `s_inc` = 1.
  - On the clock edge: state ← RUN, depth ← 0, count ← 0, `halted` ← 0, `fault` ← 0, `fault_code` ← 00.
  - Reset dominates every other event, including mid-WAIT, HALT and FAULT.
- Defaults in RUN: `s_inc` = 1, `pc_en` = 1, all other outputs 0.
- Decode and effects in RUN (control outputs are combinational from state and `opcode`; state, count, depth and status outputs are registered):
  - 000000 NOP: defaults only.
  - 001ooo ALU: `op_alu` = ooo, `we3` = 1, `wez` = 1.
  - 010000 LI: `we3` = 1, `s_inm` = 1, `s_data` = 0.
  - 010001 LD: `we3` = 1, `s_inm` = 1, `s_data` = 1.
  - 010010 ST: `we4` = 1.
  - 100000 J: `s_inc` = 0.
  - 100001 JZ: `s_inc` = ~`z`.
  - 100010 JNZ: `s_inc` = `z`.
  - 100011 CALL, depth < `STACK_DEPTH`: `push` = 1, `s_inc` = 0, depth +1.
  - 100011 CALL, depth = `STACK_DEPTH`: no push, `pc_en` = 0, go to FAULT with code 10.
  - 100100 RET, depth > 0: `pop` = 1, `s_pila` = 1, depth −1.
  - 100100 RET, depth = 0: no pop, `pc_en` = 0, go to FAULT with code 11.
  - 110000 WAIT: `pc_en` = 0, count ← `WAIT_CYCLES`−1, go to STALL.
  - 111111 HALT: `pc_en` = 0, go to HALTED; `halted` = 1 from the next cycle.
  - Any other opcode: `pc_en` = 0, no enables, go to FAULT with code 01.
- STALL state:
  - All enables 0.
  - If count ≠ 0: `pc_en` = 0, count −1.
  - If count = 0: `pc_en` = 1, `s_inc` = 1, go to RUN.
  - A WAIT therefore occupies exactly 1 + `WAIT_CYCLES` cycles and advances the PC once.
- HALTED and FAULT:
  - Absorbing: `pc_en` = 0, all enables 0, flags held.
  - Exit only via reset.
- `fault_code` is registered and set on entry to FAULT.
- Depth never wraps: the overflow/underflow checks prevent it.
- `push` and `pop` are never asserted in the same cycle.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode constants (OP_NOP, OP_ALU prefix, OP_LI, OP_LD, OP_ST, OP_J, OP_JZ, OP_JNZ, OP_CALL, OP_RET, OP_WAIT, OP_HALT);
  - state encoding RUN/STALL/HALTED/FAULT;
  - fault codes.
- One sub-module `uc_decode`: combinational opcode → raw control vector plus legal/call/ret/wait/halt flags.
- `uc_seq` holds the FSM, stall counter and depth counter, and gates the decoder outputs.

Test Plan:
- Reset held low 3 cycles, then `opcode` = 001010 → `we3` = 1, `wez` = 1, `op_alu` = 010, `pc_en` = 1, `s_inc` = 1; with `reset` low all enables are 0 and `pc_en` = 0.
- JZ (100001) with `z` = 1 → `s_inc` = 0; with `z` = 0 → `s_inc` = 1. JNZ gives the inverse. LD gives `s_inm` = `s_data` = 1, `we3` = 1. ST gives `we4` = 1 only.
- WAIT with `WAIT_CYCLES` = 4 → `pc_en` low for 4 consecutive cycles, high on the 5th; `reset` pulsed low on stall cycle 2 → RUN next cycle with `pc_en` = 1.
- 16 CALLs then a 17th → 16 push pulses, 17th gives `push` = 0, `fault` = 1, `fault_code` = 10, `pc_en` = 0 permanently.
- RET after reset (depth 0) → `pop` = 0, `fault_code` = 11. CALL then RET → `push` then `pop`/`s_pila` = 1, no fault.
- `opcode` = 011111 → `fault_code` = 01. `opcode` = 111111 → `halted` = 1, `pc_en` = 0 held 10 cycles, cleared by reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit: opcodes, sequencer states,
// fault codes and the raw control vector produced by the decoder.
package cpu_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [2:0] OP_ALU  = 3'b001;     // prefix, low 3 bits select the ALU op
  localparam logic [5:0] OP_LI   = 6'b010000;
  localparam logic [5:0] OP_LD   = 6'b010001;
  localparam logic [5:0] OP_ST   = 6'b010010;
  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_JZ   = 6'b100001;
  localparam logic [5:0] OP_JNZ  = 6'b100010;
  localparam logic [5:0] OP_CALL = 6'b100011;
  localparam logic [5:0] OP_RET  = 6'b100100;
  localparam logic [5:0] OP_WAIT = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_HALTED = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE      = 2'b00,
    FC_ILLEGAL   = 2'b01,
    FC_OVERFLOW  = 2'b10,
    FC_UNDERFLOW = 2'b11
  } fault_code_t;

  // Datapath selects and write enables for one cycle.
  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       s_data;
    logic       s_pila;
    logic       we3;
    logic       wez;
    logic       we4;
    logic       push;
    logic       pop;
    logic [2:0] op_alu;
  } ctrl_t;

  // Idle vector: PC+1 selected, everything else off.
  localparam ctrl_t CTRL_IDLE = ctrl_t'(12'b1000_0000_0000);

endpackage

// File: rtl/uc_decode.sv
// Pure combinational opcode decoder. Produces the control vector an opcode
// would drive in RUN, plus classification flags the sequencer uses to gate it.
module uc_decode
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output ctrl_t      ctrl,
  output logic       legal,
  output logic       is_call,
  output logic       is_ret,
  output logic       is_wait,
  output logic       is_halt
);

  // Map opcode to raw controls; anything not listed is flagged illegal.
  always_comb begin
    ctrl    = CTRL_IDLE;
    legal   = 1'b1;
    is_call = 1'b0;
    is_ret  = 1'b0;
    is_wait = 1'b0;
    is_halt = 1'b0;
    if (opcode[5:3] == OP_ALU) begin
      ctrl.op_alu = opcode[2:0];
      ctrl.we3    = 1'b1;
      ctrl.wez    = 1'b1;
    end else begin
      case (opcode)
        OP_NOP: ;
        OP_LI: begin
          ctrl.we3   = 1'b1;
          ctrl.s_inm = 1'b1;
        end
        OP_LD: begin
          ctrl.we3    = 1'b1;
          ctrl.s_inm  = 1'b1;
          ctrl.s_data = 1'b1;
        end
        OP_ST:  ctrl.we4   = 1'b1;
        OP_J:   ctrl.s_inc = 1'b0;
        OP_JZ:  ctrl.s_inc = ~z;
        OP_JNZ: ctrl.s_inc = z;
        OP_CALL: begin
          ctrl.push  = 1'b1;
          ctrl.s_inc = 1'b0;
          is_call    = 1'b1;
        end
        OP_RET: begin
          ctrl.pop    = 1'b1;
          ctrl.s_pila = 1'b1;
          is_ret      = 1'b1;
        end
        OP_WAIT: is_wait = 1'b1;
        OP_HALT: is_halt = 1'b1;
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit: wraps the opcode decoder with a RUN/STALL/HALTED/
// FAULT state machine, a WAIT stall counter and call-stack depth tracking.
module uc_seq
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int WAIT_CYCLES = 4,
  parameter int DEPTH_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  output logic       s_inc,
  output logic       s_inm,
  output logic       s_data,
  output logic       s_pila,
  output logic       we3,
  output logic       wez,
  output logic       we4,
  output logic       push,
  output logic       pop,
  output logic [2:0] op_alu,
  output logic       pc_en,
  output logic       halted,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  ctrl_t dec_ctrl;
  logic  dec_legal, dec_call, dec_ret, dec_wait, dec_halt;

  uc_decode u_decode (
    .opcode  (opcode),
    .z       (z),
    .ctrl    (dec_ctrl),
    .legal   (dec_legal),
    .is_call (dec_call),
    .is_ret  (dec_ret),
    .is_wait (dec_wait),
    .is_halt (dec_halt)
  );

  // Sequencer state, visible hierarchically for checkers.
  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [DEPTH_W-1:0]  depth, depth_n;
  logic                halted_q, halted_n;
  logic                fault_q, fault_n;
  fault_code_t         fc_q, fc_n;
  ctrl_t               ctrl_o;
  logic                pc_en_c;

  // Next-state and gated control outputs; reset forces the idle vector.
  always_comb begin
    ctrl_o   = CTRL_IDLE;
    pc_en_c  = 1'b0;
    state_n  = state;
    cnt_n    = cnt;
    depth_n  = depth;
    halted_n = halted_q;
    fault_n  = fault_q;
    fc_n     = fc_q;
    if (reset) begin
      case (state)
        ST_RUN: begin
          pc_en_c = 1'b1;
          if (!dec_legal) begin
            pc_en_c = 1'b0;
            state_n = ST_FAULT;
            fault_n = 1'b1;
            fc_n    = FC_ILLEGAL;
          end else if (dec_call) begin
            if (depth == DEPTH_MAX) begin
              pc_en_c = 1'b0;
              state_n = ST_FAULT;
              fault_n = 1'b1;
              fc_n    = FC_OVERFLOW;
            end else begin
              ctrl_o  = dec_ctrl;
              depth_n = depth + 1'b1;
            end
          end else if (dec_ret) begin
            if (depth == '0) begin
              pc_en_c = 1'b0;
              state_n = ST_FAULT;
              fault_n = 1'b1;
              fc_n    = FC_UNDERFLOW;
            end else begin
              ctrl_o  = dec_ctrl;
              depth_n = depth - 1'b1;
            end
          end else if (dec_wait) begin
            pc_en_c = 1'b0;
            cnt_n   = CNT_LOAD;
            state_n = ST_STALL;
          end else if (dec_halt) begin
            pc_en_c  = 1'b0;
            halted_n = 1'b1;
            state_n  = ST_HALTED;
          end else begin
            ctrl_o = dec_ctrl;
          end
        end
        ST_STALL: begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else begin
            pc_en_c = 1'b1;
            state_n = ST_RUN;
          end
        end
        default: ;  // HALTED and FAULT are absorbing
      endcase
    end
  end

  // State, counters and status flags; synchronous active-low reset wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_RUN;
      cnt      <= '0;
      depth    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      fc_q     <= FC_NONE;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      depth    <= depth_n;
      halted_q <= halted_n;
      fault_q  <= fault_n;
      fc_q     <= fc_n;
    end
  end

  assign s_inc      = ctrl_o.s_inc;
  assign s_inm      = ctrl_o.s_inm;
  assign s_data     = ctrl_o.s_data;
  assign s_pila     = ctrl_o.s_pila;
  assign we3        = ctrl_o.we3;
  assign wez        = ctrl_o.wez;
  assign we4        = ctrl_o.we4;
  assign push       = ctrl_o.push;
  assign pop        = ctrl_o.pop;
  assign op_alu     = ctrl_o.op_alu;
  assign pc_en      = pc_en_c;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_code = fc_q;

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: directed table, multi-cycle corner
// sequences and randomized opcode streams against a behavioural model.
module tb_uc_seq;

  localparam int SD = 16;
  localparam int WC = 4;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       z;
  logic       s_inc, s_inm, s_data, s_pila, we3, wez, we4, push, pop;
  logic [2:0] op_alu;
  logic       pc_en, halted, fault;
  logic [1:0] fault_code;

  uc_seq #(.STACK_DEPTH(SD), .WAIT_CYCLES(WC), .DEPTH_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z),
    .s_inc(s_inc), .s_inm(s_inm), .s_data(s_data), .s_pila(s_pila),
    .we3(we3), .wez(wez), .we4(we4), .push(push), .pop(pop),
    .op_alu(op_alu), .pc_en(pc_en), .halted(halted), .fault(fault),
    .fault_code(fault_code)
  );

  // Clock: 10 ns period, rising edges at 5, 15, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       s_inc, s_inm, s_data, s_pila, we3, wez, we4, push, pop;
    logic [2:0] op_alu;
    logic       pc_en;
  } obs_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       zv;
    obs_t       exp;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t last;

  // Behavioural model: plain flags and counters.
  bit m_halted, m_fault;
  int m_code, m_depth, m_stall_left;

  function automatic obs_t mk(bit i, bit m, bit d, bit p, bit w3, bit wz,
                              bit w4, bit pu, bit po, bit [2:0] a, bit pe);
    obs_t o;
    o = '{s_inc:i, s_inm:m, s_data:d, s_pila:p, we3:w3, wez:wz, we4:w4,
          push:pu, pop:po, op_alu:a, pc_en:pe};
    return o;
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    if (op[5:3] == 3'b001) return 1'b1;
    case (op)
      6'o00, 6'o20, 6'o21, 6'o22, 6'o40, 6'o41, 6'o42, 6'o43, 6'o44,
      6'o60, 6'o77: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic obs_t model_out(logic r, logic [5:0] op, logic zv);
    obs_t o;
    o = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    if (!r || m_halted || m_fault) return o;
    if (m_stall_left > 0) begin
      o.pc_en = (m_stall_left == 1);
      return o;
    end
    if (!is_legal(op)) return o;
    o.pc_en = 1'b1;
    if (op[5:3] == 3'b001) begin
      o.we3 = 1; o.wez = 1; o.op_alu = op[2:0];
    end else begin
      case (op)
        6'o20: begin o.we3 = 1; o.s_inm = 1; end
        6'o21: begin o.we3 = 1; o.s_inm = 1; o.s_data = 1; end
        6'o22: o.we4 = 1;
        6'o40: o.s_inc = 0;
        6'o41: o.s_inc = ~zv;
        6'o42: o.s_inc = zv;
        6'o43: if (m_depth < SD) begin o.push = 1; o.s_inc = 0; end
               else o.pc_en = 0;
        6'o44: if (m_depth > 0) begin o.pop = 1; o.s_pila = 1; end
               else o.pc_en = 0;
        6'o60, 6'o77: o.pc_en = 0;
        default: ;
      endcase
    end
    return o;
  endfunction

  task automatic model_update(logic r, logic [5:0] op);
    if (!r) begin
      m_halted = 0; m_fault = 0; m_code = 0; m_depth = 0; m_stall_left = 0;
    end else if (m_halted || m_fault) begin
    end else if (m_stall_left > 0) begin
      m_stall_left--;
    end else if (!is_legal(op)) begin
      m_fault = 1; m_code = 1;
    end else if (op == 6'o43) begin
      if (m_depth < SD) m_depth++; else begin m_fault = 1; m_code = 2; end
    end else if (op == 6'o44) begin
      if (m_depth > 0) m_depth--; else begin m_fault = 1; m_code = 3; end
    end else if (op == 6'o60) begin
      m_stall_left = WC;
    end else if (op == 6'o77) begin
      m_halted = 1;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    return mk(s_inc, s_inm, s_data, s_pila, we3, wez, we4, push, pop,
              op_alu, pc_en);
  endfunction

  // One cycle: drive at posedge+1, compare at negedge, advance the model.
  task automatic step(logic r, logic [5:0] op, logic zv);
    obs_t e;
    reset = r; opcode = op; z = zv;
    #4;
    last = sample();
    e = model_out(r, op, zv);
    chk("ctrl", 32'(last), 32'(e));
    chk("status", {29'd0, halted, fault, fault_code},
        {29'd0, m_halted, m_fault, 2'(m_code)});
    @(posedge clk);
    model_update(r, op);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b0; opcode = 6'd0; z = 1'b0;
    @(posedge clk);
    model_update(1'b0, 6'd0);
    #1;

    // Reset held low three cycles with an ALU opcode present.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'b001010, 1'b0);
      chk("rst_pc_en", 32'(last.pc_en), 0);
      chk("rst_we3", 32'(last.we3), 0);
      chk("rst_s_inc", 32'(last.s_inc), 1);
    end
    step(1'b1, 6'b001010, 1'b0);
    chk("alu_vec", 32'(last), 32'(mk(1,0,0,0,1,1,0,0,0,3'b010,1)));

    // Directed table, each entry from a fresh reset (depth 0, RUN).
    tbl.push_back('{"nop",   6'o00, 1'b0, mk(1,0,0,0,0,0,0,0,0,3'd0,1)});
    tbl.push_back('{"alu7",  6'o17, 1'b1, mk(1,0,0,0,1,1,0,0,0,3'd7,1)});
    tbl.push_back('{"li",    6'o20, 1'b0, mk(1,1,0,0,1,0,0,0,0,3'd0,1)});
    tbl.push_back('{"ld",    6'o21, 1'b0, mk(1,1,1,0,1,0,0,0,0,3'd0,1)});
    tbl.push_back('{"st",    6'o22, 1'b0, mk(1,0,0,0,0,0,1,0,0,3'd0,1)});
    tbl.push_back('{"j",     6'o40, 1'b0, mk(0,0,0,0,0,0,0,0,0,3'd0,1)});
    tbl.push_back('{"jz_z1", 6'o41, 1'b1, mk(0,0,0,0,0,0,0,0,0,3'd0,1)});
    tbl.push_back('{"jz_z0", 6'o41, 1'b0, mk(1,0,0,0,0,0,0,0,0,3'd0,1)});
    tbl.push_back('{"jnz_z1",6'o42, 1'b1, mk(1,0,0,0,0,0,0,0,0,3'd0,1)});
    tbl.push_back('{"jnz_z0",6'o42, 1'b0, mk(0,0,0,0,0,0,0,0,0,3'd0,1)});
    tbl.push_back('{"call",  6'o43, 1'b0, mk(0,0,0,0,0,0,0,1,0,3'd0,1)});
    tbl.push_back('{"ret0",  6'o44, 1'b0, mk(1,0,0,0,0,0,0,0,0,3'd0,0)});
    tbl.push_back('{"wait",  6'o60, 1'b0, mk(1,0,0,0,0,0,0,0,0,3'd0,0)});
    tbl.push_back('{"halt",  6'o77, 1'b0, mk(1,0,0,0,0,0,0,0,0,3'd0,0)});
    tbl.push_back('{"illeg", 6'o37, 1'b0, mk(1,0,0,0,0,0,0,0,0,3'd0,0)});
    foreach (tbl[i]) begin
      step(1'b0, 6'd0, 1'b0);
      step(1'b1, tbl[i].op, tbl[i].zv);
      chk(tbl[i].name, 32'(last), 32'(tbl[i].exp));
    end

    // WAIT: pc_en low for 4 cycles, high on the 5th.
    step(1'b0, 6'd0, 1'b0);
    step(1'b1, 6'o60, 1'b0);
    chk("wait_c1", 32'(last.pc_en), 0);
    for (int i = 2; i <= 4; i++) begin
      step(1'b1, 6'o00, 1'b0);
      chk("wait_low", 32'(last.pc_en), 0);
    end
    step(1'b1, 6'o00, 1'b0);
    chk("wait_c5", 32'(last.pc_en), 1);
    step(1'b1, 6'o22, 1'b0);
    chk("wait_after_st", 32'(last.we4), 1);

    // Reset pulsed on the second stall cycle returns to RUN.
    step(1'b1, 6'o60, 1'b0);
    step(1'b1, 6'o00, 1'b0);
    step(1'b0, 6'o00, 1'b0);
    step(1'b1, 6'o00, 1'b0);
    chk("wait_rst_pc_en", 32'(last.pc_en), 1);

    // Sixteen CALLs fill the stack; the 17th faults with overflow.
    step(1'b0, 6'd0, 1'b0);
    begin
      int pushes = 0;
      for (int i = 0; i < SD; i++) begin
        step(1'b1, 6'o43, 1'b0);
        if (last.push === 1'b1) pushes++;
      end
      chk("call_pushes", 32'(pushes), SD);
    end
    step(1'b1, 6'o43, 1'b0);
    chk("ovf_push", 32'(last.push), 0);
    chk("ovf_pc_en", 32'(last.pc_en), 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 6'o00, 1'b0);
      chk("ovf_hold_pc_en", 32'(last.pc_en), 0);
    end
    chk("ovf_status", {30'd0, fault, fault_code == 2'b10}, 32'd3);

    // RET at depth 0 underflows; CALL then RET is clean.
    step(1'b0, 6'd0, 1'b0);
    step(1'b1, 6'o44, 1'b0);
    chk("unf_pop", 32'(last.pop), 0);
    step(1'b1, 6'o00, 1'b0);
    chk("unf_code", 32'(fault_code), 3);
    step(1'b0, 6'd0, 1'b0);
    step(1'b1, 6'o43, 1'b0);
    chk("cr_push", 32'(last.push), 1);
    step(1'b1, 6'o44, 1'b0);
    chk("cr_pop_pila", {30'd0, last.pop, last.s_pila}, 3);
    step(1'b1, 6'o00, 1'b0);
    chk("cr_nofault", 32'(fault), 0);

    // Illegal opcode and HALT.
    step(1'b0, 6'd0, 1'b0);
    step(1'b1, 6'o37, 1'b0);
    step(1'b1, 6'o00, 1'b0);
    chk("ill_code", 32'(fault_code), 1);
    step(1'b0, 6'd0, 1'b0);
    step(1'b1, 6'o77, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 6'o00, 1'b0);
      chk("halt_hold", {30'd0, halted, last.pc_en}, 2);
    end
    step(1'b0, 6'd0, 1'b0);
    step(1'b1, 6'o00, 1'b0);
    chk("halt_cleared", {30'd0, halted, last.pc_en}, 1);

    // Randomized opcode stream against the model.
    for (int n = 0; n < 1500; n++) begin
      logic       r;
      logic [5:0] op;
      int         pick;
      r = ($urandom_range(0, 99) >= 2);
      if ((m_halted || m_fault) && $urandom_range(0, 2) == 0) r = 1'b0;
      pick = $urandom_range(0, 99);
      if      (pick < 6)  op = 6'($urandom);
      else if (pick < 8)  op = 6'o77;
      else if (pick < 28) op = 6'o43;
      else if (pick < 46) op = 6'o44;
      else if (pick < 50) op = 6'o60;
      else if (pick < 62) op = {3'b001, 3'($urandom)};
      else begin
        case ($urandom_range(0, 7))
          0: op = 6'o00; 1: op = 6'o20; 2: op = 6'o21; 3: op = 6'o22;
          4: op = 6'o40; 5: op = 6'o41; 6: op = 6'o42; default: op = 6'o00;
        endcase
      end
      step(r, op, 1'($urandom));
      if (last.push === 1'b1 && last.pop === 1'b1) chk("push_pop_excl", 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
